t_flip_flop: RTL and testbench

- Parameterised bank of WIDTH independent T (toggle) flip-flops with complementary outputs.
- Each bit inverts on a rising clock edge when its toggle input is 1 and holds when it is 0.
- Adds a global clock enable, a synchronous parallel load and an asynchronous active-low reset.
- Used as a general toggle/divider primitive; WIDTH=1 gives the classic single T flip-flop with q/qbar.

---
 rtl/t_flip_flop.sv | 80 ++++++++
 tb/tb_t_flip_flop.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent T flip-flops with complementary outputs, a global
// clock enable, a synchronous parallel load and an asynchronous active-low reset.
// Priority at each rising edge: reset > load > enable/toggle > hold.
//
// Optional feature, selected by the macro TFF_TOGGLE_CNT_EN: a 16-bit
// toggle_cnt output counting edges where bit 0 was asked to toggle (load=0,
// en=1, t[0]=1). It wraps at 0xFFFF, is cleared by reset and ignores loads.
module t_flip_flop #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
`ifdef TFF_TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: load wins over toggling; with en low every bit holds.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (en) begin
      state_d = state_q ^ t;
    end
  end

  // State register; reset acts immediately and aborts any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  // qbar is derived from the same register, so it can never equal q.
  assign q    = state_q;
  assign qbar = ~state_q;

`ifdef TFF_TOGGLE_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        cnt_inc;

  // Count only genuine bit-0 toggle requests; a load masks the request.
  assign cnt_inc = !load && en && t[0];

  // Next count; 16-bit addition wraps from 0xFFFF to 0x0000 naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared together with the flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench for t_flip_flop (WIDTH=4, RESET_VAL=0): directed steps
// followed by randomized traffic, compared against a behavioural model.
module tb_t_flip_flop;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
`ifdef TFF_TOGGLE_CNT_EN
  logic [15:0]  toggle_cnt;
`endif

  int checks;
  int errors;

  // Reference model state: the value q should hold, and the expected count.
  int unsigned exp_val;
  int unsigned exp_cnt;

  t_flip_flop #(
    .WIDTH    (W),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .t         (t),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .qbar      (qbar)
`ifdef TFF_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the DUT against the model values.
  task automatic check(input string tag);
    logic [W-1:0] e;
    e = exp_val[W-1:0];
    checks++;
    assert (q === e) else begin
      errors++;
      $error("FAIL %s q: observed %b expected %b", tag, q, e);
    end
    checks++;
    assert (qbar === ~e) else begin
      errors++;
      $error("FAIL %s qbar: observed %b expected %b", tag, qbar, ~e);
    end
`ifdef TFF_TOGGLE_CNT_EN
    checks++;
    assert (toggle_cnt === exp_cnt[15:0]) else begin
      errors++;
      $error("FAIL %s toggle_cnt: observed %h expected %h", tag, toggle_cnt, exp_cnt[15:0]);
    end
`endif
  endtask

  // Model one rising edge from the spec rules, using the pre-edge inputs.
  task automatic model_edge();
    int unsigned mask;
    mask = (1 << W) - 1;
    if (!rst_n) begin
      exp_val = 0;
      exp_cnt = 0;
    end else if (load) begin
      exp_val = int'(load_val);
    end else if (en) begin
      // Each requested bit flips: add or subtract its weight.
      for (int i = 0; i < W; i++) begin
        if (t[i]) begin
          if (((exp_val >> i) & 1) != 0) exp_val = exp_val - (1 << i);
          else exp_val = exp_val + (1 << i);
        end
      end
      if (t[0]) exp_cnt = (exp_cnt + 1) % 65536;
    end
    exp_val = exp_val & mask;
  endtask

  // Advance one edge without checking.
  task automatic edge_only();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Advance one edge and compare afterwards.
  task automatic tick(input string tag);
    edge_only();
    check(tag);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_val  = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    t        = 4'b1111;
    load     = 1'b0;
    load_val = 4'b0000;

    // Reset held: clock runs with toggle requests, q stays at reset value.
    #2;
    check("reset_async");
    repeat (3) tick("reset_held");

    // Hold: t=0 for three edges.
    rst_n = 1'b1;
    t     = 4'b0000;
    repeat (3) tick("hold");

    // Toggle every edge: 1,0,1,0 pattern on all bits.
    t = 4'b1111;
    repeat (4) tick("toggle");

    // A pulse on t while clk is low must not be seen.
    t = 4'b0000;
    @(negedge clk);
    t = 4'b1111;
    #1;
    t = 4'b0000;
    tick("t_glitch_low");

    // Single-bit toggle leaves other bits alone.
    t = 4'b0100;
    tick("bit_independent");

    // Asynchronous reset mid-cycle with q nonzero.
    t = 4'b1011;
    tick("pre_async");
    @(negedge clk);
    rst_n = 1'b0;
    exp_val = 0;
    exp_cnt = 0;
    #1;
    check("async_mid_cycle");
    @(negedge clk);
    rst_n = 1'b1;

    // Enable and multi-bit.
    en = 1'b1;
    t  = 4'b1010;
    tick("en_multibit");
    en = 1'b0;
    t  = 4'b1111;
    repeat (2) tick("en_off_hold");

    // Load beats toggle; next edge toggles the loaded value.
    en       = 1'b1;
    load     = 1'b1;
    load_val = 4'b0110;
    tick("load_priority");
    load = 1'b0;
    tick("after_load");

    // Load also works with en low.
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'b1101;
    tick("load_en_low");
    load = 1'b0;

`ifdef TFF_TOGGLE_CNT_EN
    // Counter: 5 counted edges, 2 frozen edges, then wrap and reset.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_val = 0;
    exp_cnt = 0;
    en = 1'b1;
    t  = 4'b0001;
    repeat (5) edge_only();
    en = 1'b0;
    repeat (2) edge_only();
    check("cnt_five");
    en = 1'b1;
    repeat (65535 - 5) edge_only();
    check("cnt_ffff");
    tick("cnt_wrap");
    load = 1'b1;
    tick("cnt_load_no_inc");
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_val = 0;
    exp_cnt = 0;
    #1;
    check("cnt_reset");
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        exp_val = 0;
        exp_cnt = 0;
        #1;
        check("rand_async");
        @(negedge clk);
        rst_n = 1'b1;
      end
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 7) == 0);
      t        = W'($urandom);
      load_val = W'($urandom);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
